// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared constants, coefficient type and lane helper for the NTT frame path
package ntt_pkg;

  localparam int NTT_LANES = 16;
  localparam int NTT_CW    = 4;
  localparam int NTT_QW    = 8;
  localparam int NTT_WW    = 5;

  typedef logic [NTT_CW-1:0] coeff_t;

  // Lane i of a flattened frame sits at bits [CW*i +: CW].
  function automatic coeff_t lane_get(input logic [NTT_LANES*NTT_CW-1:0] frame,
                                      input int unsigned                 lane);
    return frame[lane*NTT_CW +: NTT_CW];
  endfunction

endpackage

// File: rtl/ntt_frame_bank.sv
// rtl/ntt_frame_bank.sv - one frame buffer: LANES coefficients plus the frame's q and w
module ntt_frame_bank
  import ntt_pkg::*;
#(
  parameter int LANES = NTT_LANES,
  parameter int CW    = NTT_CW,
  parameter int QW    = NTT_QW,
  parameter int WW    = NTT_WW,
  localparam int AW   = $clog2(LANES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [CW-1:0]     wdata,
  input  logic              cap,
  input  logic [QW-1:0]     q_in,
  input  logic [WW-1:0]     w_in,
  output logic [LANES*CW-1:0] rd_coeff,
  output logic [QW-1:0]     rd_q,
  output logic [WW-1:0]     rd_w
);

  logic [CW-1:0] lane_r [LANES];
  logic [QW-1:0] q_r;
  logic [WW-1:0] w_r;

  // Cleared on reset so an empty bank never presents X on the output bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++) lane_r[i] <= '0;
      q_r <= '0;
      w_r <= '0;
    end else begin
      if (we)  lane_r[waddr] <= wdata;
      if (cap) begin
        q_r <= q_in;
        w_r <= w_in;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_flat
    assign rd_coeff[i*CW +: CW] = lane_r[i];
  end

  assign rd_q = q_r;
  assign rd_w = w_r;

endmodule

// File: rtl/ntt_frame_loader.sv
// rtl/ntt_frame_loader.sv - serial-to-frame ping-pong loader feeding the 16-point NTT stage
module ntt_frame_loader
  import ntt_pkg::*;
#(
  parameter int LANES = NTT_LANES,
  parameter int CW    = NTT_CW,
  parameter int QW    = NTT_QW,
  parameter int WW    = NTT_WW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [CW-1:0]       s_data,
  input  logic                s_last,
  input  logic [QW-1:0]       s_q,
  input  logic [WW-1:0]       s_w,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [LANES*CW-1:0] m_coeff,
  output logic [QW-1:0]       m_q,
  output logic [WW-1:0]       m_w,
  output logic                err,
  output logic [15:0]         frame_cnt
);

  localparam int AW = $clog2(LANES);

  logic [AW-1:0] cnt;
  logic          wr_sel;
  logic          rd_sel;
  logic [1:0]    bank_full;
  logic [1:0]    full_nxt;

  logic accept, at_end, complete, early, handoff;

  logic [LANES*CW-1:0] bank_coeff [2];
  logic [QW-1:0]       bank_q     [2];
  logic [WW-1:0]       bank_w     [2];

  // Ready depends only on registered state, never on m_ready.
  assign s_ready  = !bank_full[wr_sel];
  assign m_valid  = bank_full[rd_sel];
  assign accept   = s_valid && s_ready;
  assign at_end   = (cnt == AW'(LANES-1));
  assign complete = accept && at_end;
  assign early    = accept && s_last && !at_end;
  assign handoff  = m_valid && m_ready;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    ntt_frame_bank #(
      .LANES (LANES),
      .CW    (CW),
      .QW    (QW),
      .WW    (WW)
    ) u_bank (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (accept && (wr_sel == 1'(b))),
      .waddr    (cnt),
      .wdata    (s_data),
      .cap      (accept && (wr_sel == 1'(b)) && (cnt == '0)),
      .q_in     (s_q),
      .w_in     (s_w),
      .rd_coeff (bank_coeff[b]),
      .rd_q     (bank_q[b]),
      .rd_w     (bank_w[b])
    );
  end

  assign m_coeff = bank_coeff[rd_sel];
  assign m_q     = bank_q[rd_sel];
  assign m_w     = bank_w[rd_sel];

  // Completion needs an empty write bank and hand-off a full read bank, so they never collide.
  always_comb begin
    full_nxt = bank_full;
    if (handoff)  full_nxt[rd_sel] = 1'b0;
    if (complete) full_nxt[wr_sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      bank_full <= 2'b00;
      err       <= 1'b0;
      frame_cnt <= '0;
    end else if (flush) begin
      cnt       <= '0;
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      bank_full <= 2'b00;
      err       <= 1'b0;
    end else begin
      bank_full <= full_nxt;
      err       <= (complete && !s_last) || early;
      if (complete) begin
        wr_sel <= ~wr_sel;
        cnt    <= '0;
      end else if (early) begin
        cnt <= '0;
      end else if (accept) begin
        cnt <= cnt + 1'b1;
      end
      if (handoff) begin
        rd_sel    <= ~rd_sel;
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule
